config_serial_tx: RTL and testbench
===================================

Name: config_serial_tx

Overview:
Serial transmitter for the 3-wire configuration link (sen, sclk, sdata) that loads the mandelbrot engine's 52-bit configuration register. It accepts a parallel configuration word plus a start pulse and generates the sen/sclk/sdata waveform the on-chip receiver expects. The receiver synchronises all three wires through 3-flop chains, samples on sclk rising edges while sen is high, and starts rendering on sen falling.
Used on-chip as a boot/demo sequencer and in the bench as the reference driver.

Parameters:
CONFIG_WIDTH, 52, number of bits shifted per transfer.
HALF_PERIOD, 4, clk cycles per sclk low phase and per sclk high phase; must be >= 3 because of the receiver synchroniser depth.
LEAD_CYCLES, 4, clk cycles with sen high and sclk low before the first sclk low phase; must be >= 1.
TAIL_CYCLES, 4, clk cycles with sen high and sclk low after the last sclk high phase; must be >= 1.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; synchronous, active-low
start  in  1  one-cycle request; honoured only when idle
config_in  in  CONFIG_WIDTH  configuration word; captured on the accepted start cycle
busy  out  1  high while a transfer is in progress (state != IDLE)
done  out  1  one-cycle pulse in the cycle sen returns low after a completed transfer
sen  out  1  serial enable to receiver
sclk  out  1  serial clock to receiver
sdata  out  1  serial data to receiver

Behaviour:
- All outputs registered. On rst_n=0 at a clk edge: state=IDLE; busy, done, sen, sclk and sdata all 0; shift register and counters 0.
- Reset mid-transfer aborts. All outputs are 0 after that edge, with no done pulse. Because sen falls, the receiver will start a render on a partial configuration; this is accepted behaviour.
- States: IDLE, LEAD, LOW, HIGH, TAIL.
- IDLE: if start=1, capture config_in into the shift register and load phase counter = LEAD_CYCLES-1. Next cycle: state=LEAD, sen=1, sclk=0, busy=1, sdata=config_in[0].
- LEAD: sen=1, sclk=0, sdata=bit 0. After LEAD_CYCLES cycles, go to LOW.
- LOW: sclk=0 for HALF_PERIOD cycles, then go to HIGH.
- HIGH: sclk=1 for HALF_PERIOD cycles.
  - On exit, if bits remain: shift right, present the next bit on sdata and go to LOW.
  - After bit CONFIG_WIDTH-1: sclk=0 and go to TAIL.
- sdata changes only on a HIGH→LOW transition (or when entering LEAD). It is therefore stable for >= HALF_PERIOD cycles on both sides of every sclk rising edge.
- Bit order is LSB first: bit 0 is sent first. The receiver shifts in at the MSB, so after CONFIG_WIDTH rising edges its register equals config_in.
- Exactly CONFIG_WIDTH sclk rising edges per transfer; sclk is never high while sen is low.
- TAIL: sen=1, sclk=0 for TAIL_CYCLES cycles. Then state=IDLE, sen=0, busy=0, done=1 for one cycle; sdata returns to 0.
- Timing: sen is high for exactly LEAD_CYCLES + 2*HALF_PERIOD*CONFIG_WIDTH + TAIL_CYCLES cycles. With defaults this is 424.
- start while busy=1 is ignored; config_in is not re-sampled.
- start in the same cycle as done (state already IDLE) is accepted. sen then rises on the following edge, giving a 1-cycle sen-low gap.
- Counter widths: $clog2 of the largest phase length; bit counter $clog2(CONFIG_WIDTH+1). No wrap-around beyond the terminal count.

Decomposition:
- Shared package mandelbrot_cfg_pkg holds:
  - CONFIG_WIDTH=52.
  - Field offsets/widths: CR_OFFSET [15:0], CI_OFFSET [31:16], SCALING [38:32], CTR_SELECT [41:39], MAX_CTR [51:42].
  - State enum for this block.
- No sub-module needed. A phase down-counter plus bit counter live in this module.

Test Plan:
- Reset, then idle for 20 cycles → sen, sclk, sdata, busy and done all 0 throughout.
- config_in=52'h8_0123_4567_89AB, start 1 cycle, looped into a receiver model (3-flop sync, shift on sync'd sclk rise) → after done, model register = 52'h8_0123_4567_89AB. Exactly 52 sclk rises; sen high for exactly 424 cycles; done is a single pulse.
- Per-edge check in the same run → sdata constant from 4 cycles before to 3 cycles after every sclk rise; first bit is 1 (bit 0 of ...AB), second is 1, third is 0.
- start pulses at cycles 10 and 200 of a transfer with a different config_in → ignored; received word unchanged; busy stays high.
- Assert rst_n=0 at sclk edge 20 → next cycle all outputs 0, no done. After release, a new transfer with 52'hF_FFFF_FFFF_FFFF completes correctly.
- start asserted in the done cycle → new transfer accepted; sen low for exactly 1 cycle between transfers; second word received intact.

Source files
------------

// File: rtl/mandelbrot_cfg_pkg.sv
// Shared definitions for the mandelbrot configuration link: register width,
// field layout of the 52-bit configuration word and the serial transmitter states.
package mandelbrot_cfg_pkg;

  localparam int CONFIG_WIDTH = 52;

  localparam int CR_OFFSET_LSB  = 0;
  localparam int CR_OFFSET_W    = 16;
  localparam int CI_OFFSET_LSB  = 16;
  localparam int CI_OFFSET_W    = 16;
  localparam int SCALING_LSB    = 32;
  localparam int SCALING_W      = 7;
  localparam int CTR_SELECT_LSB = 39;
  localparam int CTR_SELECT_W   = 3;
  localparam int MAX_CTR_LSB    = 42;
  localparam int MAX_CTR_W      = 10;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_LEAD,
    TX_LOW,
    TX_HIGH,
    TX_TAIL
  } tx_state_t;

endpackage

// File: rtl/config_serial_tx.sv
// Drives sen/sclk/sdata to load the receiver's configuration register, LSB first.
// Every output is a flop; sdata only moves on sclk falling so it straddles each rising edge.
module config_serial_tx #(
  parameter int CONFIG_WIDTH = mandelbrot_cfg_pkg::CONFIG_WIDTH,
  parameter int HALF_PERIOD  = 4,
  parameter int LEAD_CYCLES  = 4,
  parameter int TAIL_CYCLES  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CONFIG_WIDTH-1:0] config_in,
  output logic                    busy,
  output logic                    done,
  output logic                    sen,
  output logic                    sclk,
  output logic                    sdata
);

  import mandelbrot_cfg_pkg::*;

  localparam int MAX_AB = (HALF_PERIOD > LEAD_CYCLES) ? HALF_PERIOD : LEAD_CYCLES;
  localparam int MAX_PH = (MAX_AB > TAIL_CYCLES) ? MAX_AB : TAIL_CYCLES;
  localparam int PH_W   = (MAX_PH > 1) ? $clog2(MAX_PH) : 1;
  localparam int BIT_W  = $clog2(CONFIG_WIDTH + 1);

  localparam logic [PH_W-1:0]  PH_LEAD = PH_W'(LEAD_CYCLES - 1);
  localparam logic [PH_W-1:0]  PH_HALF = PH_W'(HALF_PERIOD - 1);
  localparam logic [PH_W-1:0]  PH_TAIL = PH_W'(TAIL_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(CONFIG_WIDTH - 1);

  tx_state_t               state, state_n;
  logic [PH_W-1:0]         ph_cnt, ph_cnt_n;
  logic [BIT_W-1:0]        bit_cnt, bit_cnt_n;
  logic [CONFIG_WIDTH-1:0] shreg, shreg_n;
  logic                    busy_n, done_n, sen_n, sclk_n, sdata_n;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= TX_IDLE;
      ph_cnt  <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      sen     <= 1'b0;
      sclk    <= 1'b0;
      sdata   <= 1'b0;
    end else begin
      state   <= state_n;
      ph_cnt  <= ph_cnt_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      busy    <= busy_n;
      done    <= done_n;
      sen     <= sen_n;
      sclk    <= sclk_n;
      sdata   <= sdata_n;
    end
  end

  always_comb begin
    state_n   = state;
    ph_cnt_n  = (ph_cnt != '0) ? ph_cnt - 1'b1 : ph_cnt;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    busy_n    = busy;
    done_n    = 1'b0;
    sen_n     = sen;
    sclk_n    = sclk;
    sdata_n   = sdata;

    unique case (state)
      TX_IDLE: begin
        if (start) begin
          state_n   = TX_LEAD;
          ph_cnt_n  = PH_LEAD;
          bit_cnt_n = '0;
          shreg_n   = config_in;
          busy_n    = 1'b1;
          sen_n     = 1'b1;
          sclk_n    = 1'b0;
          sdata_n   = config_in[0];
        end
      end
      TX_LEAD: begin
        if (ph_cnt == '0) begin
          state_n  = TX_LOW;
          ph_cnt_n = PH_HALF;
        end
      end
      TX_LOW: begin
        if (ph_cnt == '0) begin
          state_n  = TX_HIGH;
          ph_cnt_n = PH_HALF;
          sclk_n   = 1'b1;
        end
      end
      TX_HIGH: begin
        if (ph_cnt == '0) begin
          sclk_n    = 1'b0;
          bit_cnt_n = bit_cnt + 1'b1;
          if (bit_cnt == BIT_LAST) begin
            state_n  = TX_TAIL;
            ph_cnt_n = PH_TAIL;
          end else begin
            // Falling edge of sclk is the only place the data bit advances.
            state_n  = TX_LOW;
            ph_cnt_n = PH_HALF;
            shreg_n  = shreg >> 1;
            sdata_n  = shreg[1];
          end
        end
      end
      TX_TAIL: begin
        if (ph_cnt == '0) begin
          state_n = TX_IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          sen_n   = 1'b0;
          sdata_n = 1'b0;
        end
      end
      default: begin
        state_n  = TX_IDLE;
        ph_cnt_n = '0;
        busy_n   = 1'b0;
        sen_n    = 1'b0;
        sclk_n   = 1'b0;
        sdata_n  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_config_serial_tx.sv
// Bench for config_serial_tx: directed transfers into a synchronising receiver model,
// with expected words queued at issue time and checked by a monitor on each done pulse.
module tb_config_serial_tx;

  localparam int W = 52;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] config_in;
  logic         busy, done, sen, sclk, sdata;

  config_serial_tx dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .config_in (config_in),
    .busy      (busy),
    .done      (done),
    .sen       (sen),
    .sclk      (sclk),
    .sdata     (sdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Receiver model and waveform monitor, sampled on the falling clock edge.
  logic         s1c = 0, s2c = 0, s3c = 0, s1e = 0, s2e = 0, s3e = 0, s1d = 0, s2d = 0, s3d = 0;
  logic         pv;
  logic [W-1:0] rx = '0;
  logic         prev_sen = 0, prev_sclk = 0, prev_sdata = 0, prev_done = 0;
  int           rises = 0, sen_len = 0, xfer = 0, since = 0, pend = 0;
  logic         pend_val = 0;
  logic [2:0]   first_bits = 3'b011;
  logic [W-1:0] e;

  always @(negedge clk) begin
    pv  = s3c;
    s3c = s2c; s2c = s1c; s1c = sclk;
    s3e = s2e; s2e = s1e; s1e = sen;
    s3d = s2d; s2d = s1d; s1d = sdata;
    if (s3c && !pv && s3e) rx = {s3d, rx[W-1:1]};

    if (sen && !prev_sen) begin
      rises = 0; sen_len = 0; xfer++;
    end
    if (sen) sen_len++;
    if (sdata == prev_sdata) since++; else since = 1;

    if (pend > 0) begin
      pend--;
      if (pend == 0) chk("sdata_hold_after_rise", (since >= 4) && (sdata == pend_val), 1);
    end
    if (sclk) chk("sclk_only_with_sen", sen, 1);
    if (sclk && !prev_sclk) begin
      rises++;
      chk("sdata_setup_before_rise", since >= 5, 1);
      pend     = 3;
      pend_val = sdata;
      if (xfer == 1 && rises <= 3) chk($sformatf("first_bit%0d", rises - 1), sdata, first_bits[rises-1]);
    end
    if (!rst_n) pend = 0;

    if (prev_done) chk("done_single_pulse", done, 0);
    if (done) begin
      if (exp_q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        e = exp_q.pop_front();
        chk("rx_word", rx, e);
        chk("sclk_rise_count", rises, 52);
        chk("sen_high_cycles", sen_len, 424);
      end
    end

    prev_sen = sen; prev_sclk = sclk; prev_sdata = sdata; prev_done = done;
  end

  // Called at a falling edge; drives start for exactly one cycle.
  task automatic send(input logic [W-1:0] w, input bit expect_done);
    config_in = w;
    start     = 1'b1;
    if (expect_done) exp_q.push_back(w);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 2000);
    if (!done) chk("done_timeout", 0, 1);
    else chk("sen_low_in_done_cycle", sen, 0);
  endtask

  initial begin
    int  r;
    int  n;
    bit  saw_done;
    logic pc;

    rst_n = 1'b0; start = 1'b0; config_in = '0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {sen, sclk, sdata, busy, done}, 5'b0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_outputs", {sen, sclk, sdata, busy, done}, 5'b0);
    end

    // Basic transfer
    send(52'h8_0123_4567_89AB, 1);
    chk("busy_after_start", busy, 1);
    wait_done();
    repeat (5) @(negedge clk);

    // Starts while busy must be ignored
    send(52'hA_5A5A_0F0F_3C3C, 1);
    repeat (8) @(negedge clk);
    config_in = 52'h1_2345_6789_ABCD;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_at_cycle10", busy, 1);
    repeat (189) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("busy_at_cycle200", busy, 1);
    wait_done();
    repeat (5) @(negedge clk);

    // Abort on the 20th sclk rising edge
    send(52'h5_5555_5555_5555, 0);
    r = 0; n = 0; pc = sclk;
    while (r < 20 && n < 2000) begin
      @(negedge clk);
      n++;
      if (sclk && !pc) r++;
      pc = sclk;
    end
    chk("abort_reached_edge20", r, 20);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_outputs_zero", {sen, sclk, sdata, busy, done}, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;
    saw_done = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) saw_done = 1;
    end
    chk("no_done_after_abort", saw_done, 0);

    // Full transfer after abort, then back-to-back start in the done cycle
    send(52'hF_FFFF_FFFF_FFFF, 1);
    wait_done();
    send(52'h0_0000_0000_0001, 1);
    chk("sen_gap_one_cycle", sen, 1);
    wait_done();

    repeat (10) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
